ro_count_serializer: RTL and testbench
======================================

Name: ro_count_serializer

Overview:
- Multi-channel readout serializer for ring-oscillator frequency counters.
- On a start request it snapshots all NUM_CH counter values coherently and transmits one framed channel, or all channels in sequence, on a single output pin.
- The output is available as a raw bit and as a Manchester-coded bit (raw XOR clk).
- Sits between the per-oscillator frequency-measurement counters and the top-level output pin; clk is supplied by the external host.

Parameters:
- NUM_CH, 4, number of counter channels (2..16).
- COUNT_W, 20, width of each counter value.
- CH_W, $clog2(NUM_CH), width of the channel index field.
- HDR, 4'b1010, frame header pattern, sent MSB first.
- HDR_W, 4, header width.
- GAP_CYCLES, 2, idle cycles between frames in scan mode (0..15).

Ports:
- clk  in  1  serial/readout clock
- reset  in  1  asynchronous reset, active high
- ena  in  1  global enable; low freezes all state
- start  in  1  frame request, level-sampled
- scan_all  in  1  1 = send all channels 0..NUM_CH-1; 0 = send ch_sel only
- ch_sel  in  CH_W  channel for single mode
- counts  in  NUM_CH*COUNT_W  flattened counter values; channel i at [i*COUNT_W +: COUNT_W]
- busy  out  1  high from accepted start until the last frame completes
- frame_valid  out  1  high while frame bits are on data_raw
- data_raw  out  1  current serial bit
- data_manchester  out  1  data_raw XOR clk (combinational)
- frame_done  out  1  one-cycle pulse after each frame's last bit
- err  out  1  one-cycle pulse on a rejected start

Behaviour:
- Reset: all outputs 0 except data_manchester (= clk); FSM goes to IDLE; snapshot and shift registers cleared.
- Reset mid-frame aborts the frame immediately. No frame_done is issued.
- ena low: FSM, counters, shift register and pulse outputs hold their values; data_manchester still follows clk.
- Frame format, MSB first: HDR (HDR_W) | channel index (CH_W) | count (COUNT_W) | check (CHK_W).
  - FRAME_W = HDR_W + CH_W + COUNT_W + CHK_W.
- Check field without the optional feature: CHK_W = 1, even parity over index and count. The total number of ones in index, count and parity is even.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - start = 1 on edge N with ena = 1 is accepted.
  - On the same edge: all NUM_CH counts are captured into snapshot registers, the shift register is loaded with the frame for the first channel, busy = 1, frame_valid = 1, and the FSM moves to SHIFT.
  - First channel is ch_sel in single mode, 0 in scan mode.
- Timing: the header MSB is on data_raw in the cycle after edge N. Bit k is on data_raw after edge N+k.
- SHIFT:
  - After edge N+FRAME_W-1 the last bit is on data_raw.
  - On edge N+FRAME_W: frame_valid = 0, data_raw = 0, frame_done = 1 for one cycle.
  - Single mode, or scan mode after channel NUM_CH-1: busy = 0 on that edge and the FSM returns to IDLE.
  - Otherwise the FSM goes to GAP.
- GAP:
  - Lasts GAP_CYCLES cycles with data_raw = 0, then loads the next channel's frame from the snapshot and returns to SHIFT.
  - With GAP_CYCLES = 0 the next frame loads on the edge that ends the previous frame. frame_done still pulses and frame_valid stays 1.
- Snapshot: all frames in one scan carry values captured at edge N. Later changes on counts are not transmitted.
- start while busy: ignored, no err. start held high: a new frame begins on the first IDLE edge.
- Invalid ch_sel (>= NUM_CH) in single mode: start is rejected, err = 1 for one cycle, FSM stays in IDLE. Not applicable in scan mode.
- Bit counter: $clog2(FRAME_W+1) bits; the counter never wraps.

Optional Feature:
- Macro: RO_SERIALIZER_CRC8_EN.
- Defined: CHK_W = 8; the check field is CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR) over the index and count bits, MSB first. The CRC is computed bit-serially while shifting, or precomputed at load; the result must be identical either way.
- Undefined: the 1-bit even parity described in Behaviour.

Test Plan:
- Single, no CRC, NUM_CH=4, COUNT_W=20: ch_sel=2, counts ch2=0x00005, start pulse.
  - data_raw sequence = 1010 10 00000000000000000101 1 (27 bits), frame_done 27 cycles after start edge, busy low the same edge.
- Scan, GAP_CYCLES=2: counts {3:0x00003, 2:0x00002, 1:0x00001, 0:0x00000}.
  - Four frames with indices 0,1,2,3, each separated by exactly 2 zero cycles, four frame_done pulses, busy high 4*27+3*2 = 114 cycles.
- Coherence: change all counts to 0xFFFFF one cycle after start in scan mode -> all frames still carry the original values.
- ena low for 5 cycles during bit 10 -> bit 10 is held for 6 cycles total, and the remaining sequence is unchanged.
- Reset asserted mid-frame at bit 12 -> outputs 0 immediately, no frame_done; a fresh start afterwards yields a complete, correct frame. Start with ch_sel=5 (NUM_CH=5, CH_W=3) -> err pulse, no frame.
- CRC8_EN, ch 1, count 0x00001 -> 8-bit check field matches the reference-model CRC-8/0x07 over the 22 index+count bits; data_manchester = data_raw XOR clk on every half cycle.

Source files
------------

// File: rtl/ro_count_serializer.sv
// Ring-oscillator count readout: coherent snapshot of NUM_CH counters, framed MSB-first serial output.
// Build option RO_SERIALIZER_CRC8_EN: CRC-8 (poly 0x07) check field instead of 1-bit even parity.
module ro_count_serializer #(
    parameter int unsigned      NUM_CH     = 4,
    parameter int unsigned      COUNT_W    = 20,
    parameter int unsigned      CH_W       = $clog2(NUM_CH),
    parameter int unsigned      HDR_W      = 4,
    parameter logic [HDR_W-1:0] HDR        = 4'b1010,
    parameter int unsigned      GAP_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ena,
    input  logic                      start,
    input  logic                      scan_all,
    input  logic [CH_W-1:0]           ch_sel,
    input  logic [NUM_CH*COUNT_W-1:0] counts,
    output logic                      busy,
    output logic                      frame_valid,
    output logic                      data_raw,
    output logic                      data_manchester,
    output logic                      frame_done,
    output logic                      err
);

`ifdef RO_SERIALIZER_CRC8_EN
    localparam int unsigned CHK_W = 8;
`else
    localparam int unsigned CHK_W = 1;
`endif
    localparam int unsigned PAY_W   = CH_W + COUNT_W;
    localparam int unsigned FRAME_W = HDR_W + PAY_W + CHK_W;
    localparam int unsigned BIT_W   = $clog2(FRAME_W + 1);
    localparam int unsigned GAP_W   = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

`ifdef RO_SERIALIZER_CRC8_EN
    function automatic logic [7:0] crc8(input logic [PAY_W-1:0] d);
        logic [7:0] c;
        c = '0;
        for (int i = PAY_W - 1; i >= 0; i--) begin
            if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else             c = {c[6:0], 1'b0};
        end
        return c;
    endfunction
`endif

    logic [1:0]                       r_state;
    logic [NUM_CH-1:0][COUNT_W-1:0]   r_snap;
    logic [FRAME_W-1:0]               r_shift;
    logic [BIT_W-1:0]                 r_bit_cnt;
    logic [GAP_W-1:0]                 r_gap_cnt;
    logic [CH_W-1:0]                  r_ch;
    logic                             r_scan;
    logic                             r_busy;
    logic                             r_valid;
    logic                             r_data;
    logic                             r_done;
    logic                             r_err;

    logic [NUM_CH-1:0][COUNT_W-1:0]   w_cnt_in;
    logic [1:0]                       w_state_nxt;
    logic                             w_accept;
    logic                             w_reject;
    logic                             w_load;
    logic                             w_end;
    logic                             w_last;
    logic [CH_W-1:0]                  w_load_ch;
    logic [COUNT_W-1:0]               w_load_cnt;
    logic [PAY_W-1:0]                 w_payload;
    logic [CHK_W-1:0]                 w_chk;
    logic [FRAME_W-1:0]               w_frame;
    logic                             w_ch_bad;

    assign w_cnt_in = counts;
    assign w_ch_bad = ({1'b0, ch_sel} >= (CH_W + 1)'(NUM_CH));

    // Next-state and control decode
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_load      = 1'b0;
        w_end       = 1'b0;
        w_last      = 1'b0;
        w_load_ch   = r_ch;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (!scan_all && w_ch_bad) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_load      = 1'b1;
                        w_load_ch   = scan_all ? '0 : ch_sel;
                        w_state_nxt = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (r_bit_cnt == BIT_W'(FRAME_W)) begin
                    w_end  = 1'b1;
                    w_last = !r_scan || (r_ch == CH_W'(NUM_CH - 1));
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                    end else if (GAP_CYCLES == 0) begin
                        w_load    = 1'b1;
                        w_load_ch = r_ch + CH_W'(1);
                    end else begin
                        w_state_nxt = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    w_load      = 1'b1;
                    w_load_ch   = r_ch + CH_W'(1);
                    w_state_nxt = S_SHIFT;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The first frame is built from live counts because the snapshot is captured on the same edge
    always_comb begin
        w_load_cnt = (r_state == S_IDLE) ? w_cnt_in[w_load_ch] : r_snap[w_load_ch];
        w_payload  = {w_load_ch, w_load_cnt};
`ifdef RO_SERIALIZER_CRC8_EN
        w_chk      = crc8(w_payload);
`else
        w_chk      = ^w_payload;
`endif
        w_frame    = {HDR, w_payload, w_chk};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_snap    <= '0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_ch      <= '0;
            r_scan    <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else if (ena) begin
            r_state <= w_state_nxt;
            r_err   <= w_reject;
            r_done  <= w_end;
            if (w_accept) begin
                r_snap <= w_cnt_in;
                r_scan <= scan_all;
                r_busy <= 1'b1;
            end
            if (w_load) begin
                r_ch      <= w_load_ch;
                r_data    <= w_frame[FRAME_W-1];
                r_shift   <= {w_frame[FRAME_W-2:0], 1'b0};
                r_bit_cnt <= BIT_W'(1);
                r_valid   <= 1'b1;
                r_gap_cnt <= '0;
            end else if (w_end) begin
                r_data    <= 1'b0;
                r_valid   <= 1'b0;
                r_gap_cnt <= '0;
                if (w_last) r_busy <= 1'b0;
            end else if (r_state == S_SHIFT) begin
                r_data    <= r_shift[FRAME_W-1];
                r_shift   <= {r_shift[FRAME_W-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end else if (r_state == S_GAP) begin
                r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end
        end
    end

    assign busy            = r_busy;
    assign frame_valid     = r_valid;
    assign data_raw        = r_data;
    assign frame_done      = r_done;
    assign err             = r_err;
    assign data_manchester = r_data ^ clk;

endmodule

// File: tb/tb_ro_count_serializer.sv
// Directed bench for ro_count_serializer; honours RO_SERIALIZER_CRC8_EN for the check field.
module tb_ro_count_serializer;

`ifdef RO_SERIALIZER_CRC8_EN
    localparam int unsigned FRAME_W = 34;
`else
    localparam int unsigned FRAME_W = 27;
`endif
    localparam int unsigned FRAME5_W = FRAME_W + 1;
    localparam int unsigned GAP      = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ena = 1'b1;
    logic        start = 1'b0;
    logic        scan_all = 1'b0;
    logic [1:0]  ch_sel = 2'd0;
    logic [79:0] counts = '0;
    logic        busy, frame_valid, data_raw, data_manchester, frame_done, err;

    logic        start5 = 1'b0;
    logic        scan_all5 = 1'b0;
    logic [2:0]  ch_sel5 = 3'd0;
    logic [99:0] counts5 = '0;
    logic        busy5, fv5, dr5, dm5, fd5, err5;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ro_count_serializer dut (
        .clk(clk), .reset(reset), .ena(ena), .start(start), .scan_all(scan_all),
        .ch_sel(ch_sel), .counts(counts), .busy(busy), .frame_valid(frame_valid),
        .data_raw(data_raw), .data_manchester(data_manchester),
        .frame_done(frame_done), .err(err)
    );

    ro_count_serializer #(.NUM_CH(5)) dut5 (
        .clk(clk), .reset(reset), .ena(ena), .start(start5), .scan_all(scan_all5),
        .ch_sel(ch_sel5), .counts(counts5), .busy(busy5), .frame_valid(fv5),
        .data_raw(dr5), .data_manchester(dm5), .frame_done(fd5), .err(err5)
    );

`ifdef RO_SERIALIZER_CRC8_EN
    // Long-division form: message followed by eight zero bits
    function automatic logic [7:0] ref_crc8(input logic [21:0] p);
        logic [8:0] r;
        r = '0;
        for (int i = 21; i >= -8; i--) begin
            r = {r[7:0], (i >= 0) ? p[i] : 1'b0};
            if (r[8]) r = r ^ 9'h107;
        end
        return r[7:0];
    endfunction
`endif

    function automatic logic [FRAME_W-1:0] exp_frame(input logic [1:0] ch, input logic [19:0] c);
        logic [21:0] p;
        p = {ch, c};
`ifdef RO_SERIALIZER_CRC8_EN
        return {4'b1010, p, ref_crc8(p)};
`else
        return {4'b1010, p, ^p};
`endif
    endfunction

    task automatic pulse_start(input logic scan, input logic [1:0] ch);
        scan_all = scan;
        ch_sel   = ch;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Collect one frame, first sample taken at the current negedge
    task automatic grab(output logic [FRAME_W-1:0] v, output int nbad, output int nbusy);
        nbad  = 0;
        nbusy = 0;
        for (int k = 0; k < int'(FRAME_W); k++) begin
            v[FRAME_W-1-k] = data_raw;
            if (frame_valid !== 1'b1 || frame_done !== 1'b0) nbad++;
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({busy, frame_valid, data_raw, frame_done, err} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_outputs got=%b want=00000", {busy, frame_valid, data_raw, frame_done, err});
        end
        n_checks++;
        if (data_manchester !== clk) begin
            n_errors++;
            $display("FAIL reset_manchester_low got=%b want=%b", data_manchester, clk);
        end
        @(posedge clk); #1;
        n_checks++;
        if (data_manchester !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_manchester_high got=%b want=1", data_manchester);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [FRAME_W-1:0] v, exp;
        int nbad, nbusy;
        counts = '0;
        counts[2*20 +: 20] = 20'h00005;
        counts[1*20 +: 20] = 20'hFFFFF;
`ifndef RO_SERIALIZER_CRC8_EN
        exp = {4'b1010, 2'b10, 20'h00005, 1'b1};
`else
        exp = exp_frame(2'd2, 20'h00005);
`endif
        pulse_start(1'b0, 2'd2);
        grab(v, nbad, nbusy);
        n_checks++;
        if (v !== exp) begin
            n_errors++;
            $display("FAIL single_frame got=%h want=%h", v, exp);
        end
        n_checks++;
        if (nbad !== 0 || nbusy !== int'(FRAME_W)) begin
            n_errors++;
            $display("FAIL single_framing bad=%0d busy=%0d want 0/%0d", nbad, nbusy, FRAME_W);
        end
        n_checks++;
        if ({frame_done, busy, frame_valid, data_raw} !== 4'b1000) begin
            n_errors++;
            $display("FAIL single_end got=%b want=1000", {frame_done, busy, frame_valid, data_raw});
        end
        @(negedge clk);
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_errors++;
            $display("FAIL single_done_width got=%b want=0", frame_done);
        end
    endtask

    // Scan all channels; optionally overwrite counts one cycle after start
    task automatic run_scan(input logic clobber, input logic [19:0] base, input string tag);
        logic [FRAME_W-1:0] v;
        int nbad, nbusy, busy_total, gap_bad, end_bad, frame_bad;
        busy_total = 0; gap_bad = 0; end_bad = 0; frame_bad = 0;
        for (int i = 0; i < 4; i++) counts[i*20 +: 20] = base + 20'(i);
        pulse_start(1'b1, 2'd3);
        if (clobber) counts = {80{1'b1}};
        for (int f = 0; f < 4; f++) begin
            grab(v, nbad, nbusy);
            busy_total += nbusy;
            if (v !== exp_frame(2'(f), base + 20'(f)) || nbad !== 0) begin
                frame_bad++;
                $display("  %s frame %0d got=%h want=%h", tag, f, v, exp_frame(2'(f), base + 20'(f)));
            end
            if (frame_done !== 1'b1 || data_raw !== 1'b0) end_bad++;
            if (f < 3) begin
                for (int g = 0; g < int'(GAP); g++) begin
                    if (data_raw !== 1'b0 || frame_valid !== 1'b0) gap_bad++;
                    if (busy === 1'b1) busy_total++;
                    @(negedge clk);
                end
            end
        end
        n_checks++;
        if (frame_bad !== 0) begin
            n_errors++;
            $display("FAIL %s_frames bad=%0d want=0", tag, frame_bad);
        end
        n_checks++;
        if (gap_bad !== 0 || end_bad !== 0) begin
            n_errors++;
            $display("FAIL %s_gaps gap_bad=%0d end_bad=%0d want 0/0", tag, gap_bad, end_bad);
        end
        n_checks++;
        if (busy_total !== int'(4*FRAME_W + 3*GAP) || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_busy got=%0d/%b want=%0d/0", tag, busy_total, busy, 4*FRAME_W + 3*GAP);
        end
        @(negedge clk);
    endtask

    task automatic test_scan();
        run_scan(1'b0, 20'h00000, "scan");
    endtask

    task automatic test_coherence();
        run_scan(1'b1, 20'h5A3C0, "coherence");
    endtask

    task automatic test_ena_hold();
        logic [FRAME_W-1:0] exp;
        int nbad, k;
        counts[1*20 +: 20] = 20'h3C5A1;
        exp = exp_frame(2'd1, 20'h3C5A1);
        nbad = 0;
        pulse_start(1'b0, 2'd1);
        for (int s = 0; s < int'(FRAME_W) + 5; s++) begin
            k = (s <= 10) ? s : ((s <= 15) ? 10 : s - 5);
            if (data_raw !== exp[FRAME_W-1-k] || frame_valid !== 1'b1) nbad++;
            if (s == 10) ena = 1'b0;
            if (s == 15) ena = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (nbad !== 0) begin
            n_errors++;
            $display("FAIL ena_hold_stream bad_samples=%0d want=0", nbad);
        end
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_errors++;
            $display("FAIL ena_hold_done got=%b want=1", frame_done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        logic [FRAME_W-1:0] v, exp;
        int nbad, nbusy, stray;
        counts[3*20 +: 20] = 20'h8F0F3;
        exp = exp_frame(2'd3, 20'h8F0F3);
        pulse_start(1'b0, 2'd3);
        for (int k = 0; k < 12; k++) @(negedge clk);
        n_checks++;
        if (data_raw !== exp[FRAME_W-1-12]) begin
            n_errors++;
            $display("FAIL abort_bit12 got=%b want=%b", data_raw, exp[FRAME_W-1-12]);
        end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, frame_valid, data_raw, frame_done, err} !== 5'b0) begin
            n_errors++;
            $display("FAIL abort_outputs got=%b want=00000", {busy, frame_valid, data_raw, frame_done, err});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        for (int k = 0; k < 30; k++) begin
            if (frame_done !== 1'b0 || frame_valid !== 1'b0 || busy !== 1'b0) stray++;
            @(negedge clk);
        end
        n_checks++;
        if (stray !== 0) begin
            n_errors++;
            $display("FAIL abort_no_done stray=%0d want=0", stray);
        end
        pulse_start(1'b0, 2'd3);
        grab(v, nbad, nbusy);
        n_checks++;
        if (v !== exp || nbad !== 0 || frame_done !== 1'b1) begin
            n_errors++;
            $display("FAIL abort_restart got=%h want=%h bad=%0d done=%b", v, exp, nbad, frame_done);
        end
        @(negedge clk);
    endtask

    task automatic test_bad_channel();
        counts5[4*20 +: 20] = 20'h00003;
        ch_sel5 = 3'd5;
        start5  = 1'b1;
        @(negedge clk);
        start5  = 1'b0;
        n_checks++;
        if ({err5, busy5, fv5, dr5} !== 4'b1000) begin
            n_errors++;
            $display("FAIL bad_ch_err got=%b want=1000", {err5, busy5, fv5, dr5});
        end
        @(negedge clk);
        n_checks++;
        if ({err5, busy5, fv5, dm5} !== 4'b0000) begin
            n_errors++;
            $display("FAIL bad_ch_pulse got=%b want=0000", {err5, busy5, fv5, dm5});
        end
        ch_sel5 = 3'd4;
        start5  = 1'b1;
        @(negedge clk);
        start5  = 1'b0;
        n_checks++;
        if ({err5, busy5, fv5, dr5} !== 4'b0111) begin
            n_errors++;
            $display("FAIL ch4_accept got=%b want=0111", {err5, busy5, fv5, dr5});
        end
        for (int k = 0; k < int'(FRAME5_W) - 1; k++) @(negedge clk);
        n_checks++;
        if (busy5 !== 1'b1) begin
            n_errors++;
            $display("FAIL ch4_busy_len got=%b want=1", busy5);
        end
        @(negedge clk);
        n_checks++;
        if ({busy5, fd5} !== 2'b01) begin
            n_errors++;
            $display("FAIL ch4_end got=%b want=01", {busy5, fd5});
        end
        @(negedge clk);
    endtask

    task automatic test_check_field();
        logic [FRAME_W-1:0] v, exp;
        int nman;
        counts[1*20 +: 20] = 20'h00001;
        exp  = exp_frame(2'd1, 20'h00001);
        nman = 0;
        pulse_start(1'b0, 2'd1);
        for (int k = 0; k < int'(FRAME_W); k++) begin
            v[FRAME_W-1-k] = data_raw;
            if (data_manchester !== data_raw) nman++;
            @(posedge clk); #1;
            if (data_manchester !== ~data_raw) nman++;
            @(negedge clk);
        end
        n_checks++;
        if (v[7:0] !== exp[7:0] || v !== exp) begin
            n_errors++;
            $display("FAIL check_field got=%h want=%h", v, exp);
        end
        n_checks++;
        if (nman !== 0) begin
            n_errors++;
            $display("FAIL manchester bad_half_cycles=%0d want=0", nman);
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_scan();
        test_coherence();
        test_ena_hold();
        test_reset_abort();
        test_bad_channel();
        test_check_field();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
